// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state type and constants for mem_handle_responder
package mem_resp_pkg;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_RD_LAT_MAX = 7;
  typedef enum logic [2:0] {IDLE, RD_WAIT, WR, WT_PUSH, DONE, DRAIN} mem_resp_state_t;
endpackage

// File: rtl/mem_resp_sram.sv
// mem_resp_sram: single-port synchronous SRAM with an RD_LAT-stage read pipeline
module mem_resp_sram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [MEM_DATA_W-1:0] wdata,
  output logic [MEM_DATA_W-1:0] rdata
);
  logic [MEM_DATA_W-1:0] mem [DEPTH];
  logic [MEM_DATA_W-1:0] pipe [RD_LAT];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    pipe[0] <= mem[addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rdata = pipe[RD_LAT-1];
endmodule

// File: rtl/mem_handle_responder.sv
// mem_handle_responder: mem_handle request FSM over a local SRAM with a write-through port.
// Define MEM_RESP_BOUNDS_CHECK_EN to flag and suppress accesses at or beyond DEPTH.
module mem_handle_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DEPTH        = 1024,
  parameter int RD_LAT       = 2,
  parameter int REGION_BEGIN = 0,
  parameter int REGION_END   = DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_avail,
  input  logic                  req_r_en,
  input  logic                  req_w_en,
  input  logic                  req_write_through,
  input  logic [ADDR_W-1:0]     req_ptr,
  input  logic [MEM_DATA_W-1:0] req_data_store,
  output logic                  rsp_done,
  output logic [MEM_DATA_W-1:0] rsp_data_load,
  output logic [ADDR_W-1:0]     region_begin,
  output logic [ADDR_W-1:0]     region_end,
  output logic                  wt_valid,
  input  logic                  wt_ready,
  output logic [ADDR_W-1:0]     wt_addr,
  output logic [MEM_DATA_W-1:0] wt_data,
  output logic                  err
);
  localparam int AW = $clog2(DEPTH);
  mem_resp_state_t state;
  logic [2:0] cnt;
  logic wt_q;
  logic oob;
  logic [MEM_DATA_W-1:0] rdata;
  assign region_begin = ADDR_W'(REGION_BEGIN);
  assign region_end = ADDR_W'(REGION_END);
  // wt_addr/wt_data double as the latched request pointer and store data
  mem_resp_sram #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) u_sram (
    .clk   (clk),
    .we    (state == WR && !oob),
    .addr  (wt_addr[AW-1:0]),
    .wdata (wt_data),
    .rdata (rdata)
  );
`ifndef MEM_RESP_BOUNDS_CHECK_EN
  assign oob = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rsp_done <= 1'b0;
      rsp_data_load <= '0;
      wt_valid <= 1'b0;
      wt_addr <= '0;
      wt_data <= '0;
      wt_q <= 1'b0;
      cnt <= '0;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
      oob <= 1'b0;
      err <= 1'b0;
`endif
    end else begin
      rsp_done <= 1'b0;
      case (state)
        IDLE: if (req_avail && (req_w_en || req_r_en)) begin
          wt_addr <= req_ptr;
          wt_data <= req_data_store;
          wt_q <= req_write_through;
          cnt <= '0;
          state <= req_w_en ? WR : RD_WAIT;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
          oob <= 32'(req_ptr) >= DEPTH;
          err <= err | (32'(req_ptr) >= DEPTH);
`endif
        end
        RD_WAIT: if (cnt == 3'(RD_LAT)) begin
          rsp_data_load <= oob ? '0 : rdata;
          rsp_done <= 1'b1;
          state <= DONE;
        end else cnt <= cnt + 3'd1;
        WR: if (wt_q && !oob) begin
          wt_valid <= 1'b1;
          state <= WT_PUSH;
        end else begin
          rsp_done <= 1'b1;
          state <= DONE;
        end
        WT_PUSH: if (wt_ready) begin
          wt_valid <= 1'b0;
          rsp_done <= 1'b1;
          state <= DONE;
        end
        DONE: state <= DRAIN;
        DRAIN: if (!req_avail) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_handle_responder.sv
// tb_mem_handle_responder: randomized transactions checked every cycle against a timing/memory model
module tb_mem_handle_responder;
  localparam int ADDR_W = 16;
  localparam int DEPTH = 1024;
  localparam int RD_LAT = 2;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic req_avail = 0, req_r_en = 0, req_w_en = 0, req_write_through = 0;
  logic [ADDR_W-1:0] req_ptr = 0;
  logic [31:0] req_data_store = 0;
  logic rsp_done, wt_valid, err;
  logic wt_ready = 0;
  logic [31:0] rsp_data_load, wt_data;
  logic [ADDR_W-1:0] region_begin, region_end, wt_addr;
  mem_handle_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_avail(req_avail), .req_r_en(req_r_en), .req_w_en(req_w_en),
    .req_write_through(req_write_through), .req_ptr(req_ptr), .req_data_store(req_data_store),
    .rsp_done(rsp_done), .rsp_data_load(rsp_data_load), .region_begin(region_begin),
    .region_end(region_end), .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_addr(wt_addr),
    .wt_data(wt_data), .err(err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  int exp_done = -1, wt_lo = -1, wt_hi = -2, err_from = -1;
  logic [31:0] load_old = 0, load_new = 0, exp_wd = 0;
  logic [ADDR_W-1:0] exp_wa = 0;
  logic [31:0] mdl [int];
  int last_done = -1, last_t0 = 0, done_cnt = 0;
  logic [31:0] last_load = 0;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, got, want);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("rsp_done", 32'(rsp_done), 32'(cyc == exp_done));
    chk("rsp_data_load", rsp_data_load, (exp_done >= 0 && cyc >= exp_done) ? load_new : load_old);
    chk("wt_valid", 32'(wt_valid), 32'(cyc >= wt_lo && cyc <= wt_hi));
    if (cyc >= wt_lo && cyc <= wt_hi) begin
      chk("wt_addr", 32'(wt_addr), 32'(exp_wa));
      chk("wt_data", wt_data, exp_wd);
    end
    chk("err", 32'(err), 32'(err_from >= 0 && cyc >= err_from));
    chk("region_end", 32'(region_end), DEPTH);
    if (rsp_done) begin
      last_done = cyc;
      last_load = rsp_data_load;
      done_cnt++;
    end
  end
  task automatic txn(input bit w, r, wt, input logic [ADDR_W-1:0] p, input logic [31:0] d,
                     input int k, hold, gap);
    int t0, dc, idx;
    bit oob, wt_eff;
    @(posedge clk); #1;
    t0 = cyc;
    last_t0 = t0;
    req_avail = 1; req_w_en = w; req_r_en = r; req_write_through = wt;
    req_ptr = p; req_data_store = d; wt_ready = 0;
    if (!w && !r) begin
      repeat (3) begin
        @(posedge clk); #1;
        req_ptr = 16'($urandom); req_data_store = $urandom; req_write_through = 1'($urandom);
      end
      req_avail = 0;
      return;
    end
    oob = BC && (int'(p) >= DEPTH);
    idx = int'(p) % DEPTH;
    wt_eff = w && wt && !oob;
    load_new = load_old;
    if (w) begin
      if (!oob) mdl[idx] = d;
      if (wt_eff) begin
        wt_lo = t0 + 2; wt_hi = t0 + 2 + k; exp_wa = p; exp_wd = d;
        dc = t0 + 3 + k;
      end else dc = t0 + 2;
    end else begin
      load_new = oob ? 32'h0 : mdl[idx];
      dc = t0 + RD_LAT + 2;
    end
    exp_done = dc;
    if (oob && err_from < 0) err_from = t0 + 1;
    while (cyc < dc + hold) begin
      @(posedge clk); #1;
      req_w_en = 1'($urandom); req_r_en = 1'($urandom); req_write_through = 1'($urandom);
      req_ptr = 16'($urandom); req_data_store = $urandom;
      wt_ready = wt_eff ? (cyc >= t0 + 2 + k) : 1'($urandom);
    end
    @(posedge clk); #1;
    req_avail = 0; wt_ready = 0;
    load_old = load_new; exp_done = -1; wt_lo = -1; wt_hi = -2;
    repeat (gap) @(posedge clk);
  endtask
  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    chk("rst_load", rsp_data_load, 32'h0);
    chk("rst_wt_addr", 32'(wt_addr), 32'h0);
    chk("rst_done", 32'(rsp_done), 32'h0);
    for (int i = 0; i < 16; i++) txn(1, 0, 0, 16'(i), 32'hA500_0000 + 32'(i), 0, 0, 0);
    txn(1, 0, 0, 16'(DEPTH - 1), 32'hA500_03FF, 0, 0, 0);
    txn(1, 0, 0, 16'd5, 32'h3F80_0000, 0, 0, 1);
    chk("wr_latency", 32'(last_done - last_t0), 32'd2);
    txn(0, 1, 0, 16'd5, 32'h0, 0, 0, 1);
    chk("rd_latency", 32'(last_done - last_t0), 32'd4);
    chk("rd_data_5", last_load, 32'h3F80_0000);
    d0 = done_cnt;
    txn(1, 0, 0, 16'd0, 32'h1111_0000, 0, 2, 0);
    txn(1, 0, 0, 16'd1, 32'h2222_0001, 0, 0, 0);
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    txn(0, 1, 0, 16'd0, 32'h0, 0, 1, 0);
    chk("rd_data_0", last_load, 32'h1111_0000);
    txn(0, 1, 0, 16'd1, 32'h0, 0, 0, 0);
    chk("rd_data_1", last_load, 32'h2222_0001);
    txn(1, 0, 1, 16'd9, 32'hDEAD_BEEF, 3, 0, 0);
    chk("wt_latency", 32'(last_done - last_t0), 32'd6);
    txn(1, 1, 0, 16'd2, 32'd7, 0, 0, 0);
    txn(0, 1, 0, 16'd2, 32'h0, 0, 0, 0);
    chk("both_en_write", last_load, 32'd7);
    txn(0, 1, 0, 16'(DEPTH + 3), 32'h0, 0, 0, 0);
    chk("oob_rd_latency", 32'(last_done - last_t0), 32'd4);
`ifdef MEM_RESP_BOUNDS_CHECK_EN
    chk("oob_rd_data", last_load, 32'h0);
    chk("oob_err", 32'(err), 32'h1);
`else
    chk("alias_rd_data", last_load, 32'hA500_0003);
`endif
    // reset during RD_WAIT: abort, no done, outputs back to reset values
    txn(0, 1, 0, 16'd4, 32'h0, 0, 0, 0);
    @(posedge clk); #1;
    req_avail = 1; req_r_en = 1; req_w_en = 0; req_ptr = 16'd4;
    exp_done = cyc + RD_LAT + 2; load_new = mdl[4];
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; chk_en = 0;
    @(posedge clk); #1;
    rst = 0; req_avail = 0;
    exp_done = -1; load_old = 0; load_new = 0; err_from = -1; wt_lo = -1; wt_hi = -2;
    chk_en = 1;
    chk("rst_mid_load", rsp_data_load, 32'h0);
    chk("rst_mid_err", 32'(err), 32'h0);
    txn(0, 1, 0, 16'd4, 32'h0, 0, 0, 0);
    chk("post_rst_rd", last_load, 32'hA500_0004);
    for (int n = 0; n < 150; n++) begin
      logic [ADDR_W-1:0] p;
      p = ($urandom_range(0, 3) == 0) ? 16'(DEPTH + int'($urandom_range(0, 15)))
        : ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
      txn(1'($urandom), 1'($urandom), 1'($urandom), p, $urandom,
          int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
